pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Registered program-counter unit; successor to the combinational PC adder.
- Holds the fetch PC in a register and advances it by a parametrised instruction size.
- Supports branch redirect, pipeline stall, and a halt/resume state machine; an optional return-address stack adds call/return.
- Sits between the fetch stage (consumes `pc_out`/`pc_valid`) and the decode/branch-resolution logic (drives the control inputs).

Parameters:
- INST_ADDR_WIDTH, 16, width of every address port and the PC register.
- NUM_BYTES_IN_INST, 2, increment applied per sequential instruction.
- RESET_VECTOR, 0, value loaded into the PC on reset.
- RAS_DEPTH, 4, return-address-stack entries (power of two, ≥2; used only with PC_SEQ_RAS_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold the PC this cycle (pipeline back-pressure).
- halt  in  1  enter the HALTED state.
- resume  in  1  leave the HALTED state.
- branch  in  1  redirect the PC to `branch_addr`.
- branch_addr  in  INST_ADDR_WIDTH  branch/call target.
- call  in  1  push return address, jump to `branch_addr` (RAS).
- ret  in  1  pop return address into the PC (RAS).
- pc_out  out  INST_ADDR_WIDTH  registered current fetch PC.
- pc_valid  out  1  `pc_out` is a valid fetch address this cycle.
- halted  out  1  state == HALTED.
- ras_overflow  out  1  one-cycle pulse: call made while the stack was full.
- ras_underflow  out  1  one-cycle pulse: ret made while the stack was empty.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-high.
  - While `rst` is high: `pc_out` = RESET_VECTOR, state = RUN, `pc_valid` = 0, `halted` = 0, both RAS flags = 0, RAS pointer/count = 0.
  - `pc_valid` rises at the first clock edge after `rst` deasserts.
  - Reset mid-operation (any state, any stall) aborts everything immediately; RAS contents become don't-care.
- States: RUN, HALTED.
  - RUN: `pc_valid` = 1 (after the first post-reset edge), `halted` = 0.
  - HALTED: `pc_valid` = 0, `halted` = 1, `pc_out` frozen, all other inputs ignored.
- Per-edge priority in RUN, highest first: halt > stall > ret > call > branch > increment.
  - halt: go to HALTED; `pc_out` unchanged.
  - stall: `pc_out` unchanged; call/ret/branch this cycle are dropped, not queued.
  - branch: `pc_out` <= `branch_addr`, taken as-is (no alignment masking).
  - increment: `pc_out` <= `pc_out` + NUM_BYTES_IN_INST, modulo 2^INST_ADDR_WIDTH. 0xFFFE+2 wraps to 0x0000 at width 16.
- HALTED -> RUN: `resume` high at an edge. `pc_out` is unchanged, so the held PC is re-fetched. `pc_valid` = 1 from that edge.
- `resume` in RUN is ignored. `halt` and `resume` together while HALTED: stay HALTED.
- Latency: every redirect appears on `pc_out` one edge after its input is sampled; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: PC_SEQ_RAS_EN.
- Defined — circular return-address stack of RAS_DEPTH entries:
  - call: push `pc_out` + NUM_BYTES_IN_INST, then `pc_out` <= `branch_addr`.
  - call when full: overwrite the oldest entry, count stays RAS_DEPTH, pulse `ras_overflow`.
  - ret when non-empty: `pc_out` <= top entry, pop.
  - ret when empty: behave as increment, pulse `ras_underflow`.
  - ret and call together: ret wins, call ignored, no push.
  - Stalled or halted cycles never modify the stack.
- Not defined:
  - No stack storage.
  - call behaves exactly as branch (no push).
  - ret is ignored (the next lower-priority input acts).
  - `ras_overflow` and `ras_underflow` tied to 0.

Test Plan:
- Reset, then 3 free-run edges -> `pc_out` 0x0000, 0x0002, 0x0004, 0x0006; `pc_valid` 0 during reset, 1 after the first edge.
- `pc_out` = 0xFFFE, no control inputs -> next `pc_out` 0x0000; with NUM_BYTES_IN_INST = 4 and width 8, 0xFC -> 0x00.
- At `pc_out` = 0x0010: branch to 0x0100 with stall high -> `pc_out` stays 0x0010 and the branch is lost. Branch with stall low -> `pc_out` 0x0100 next edge.
- Halt at 0x0020 -> `halted` = 1, `pc_valid` = 0. Branch/stall while halted -> `pc_out` stays 0x0020. Resume -> RUN, `pc_out` 0x0020, then 0x0022.
- (RAS_EN, depth 4) calls at 0x0010, 0x0100, 0x0200, 0x0300, 0x0400 with targets 0x0100..0x0500 -> 5th call pulses `ras_overflow`. Five rets return 0x0402, 0x0302, 0x0202, 0x0102, then the 5th pulses `ras_underflow` and increments.
- `rst` asserted asynchronously mid-cycle while HALTED with stack non-empty -> `pc_out` = RESET_VECTOR immediately, state = RUN after release, next ret underflows.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch program counter.
//   Advances the PC by NUM_BYTES_IN_INST per cycle. Supports branch redirect,
//   stall, and a RUN/HALTED state machine. All outputs are registered, so no
//   input reaches an output combinationally.
//   Optional return-address stack: define PC_SEQ_RAS_EN to add call/ret.
//   Without it, call acts as branch and ret is ignored.
// Ports:
//   i_clk, i_rst                 clock; asynchronous active-high reset
//   i_stall, i_halt, i_resume    flow control
//   i_branch, i_branch_addr      redirect; the address is also the call target
//   i_call, i_ret                RAS push/jump and pop
//   o_pc_out, o_pc_valid         fetch address and its qualifier
//   o_halted                     state is HALTED
//   o_ras_overflow/underflow     one-cycle pulses from the RAS
module pc_sequencer #(
  parameter int          INST_ADDR_WIDTH   = 16,
  parameter int          NUM_BYTES_IN_INST = 2,
  parameter int unsigned RESET_VECTOR      = 0,
  parameter int          RAS_DEPTH         = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_stall,
  input  logic                       i_halt,
  input  logic                       i_resume,
  input  logic                       i_branch,
  input  logic [INST_ADDR_WIDTH-1:0] i_branch_addr,
  input  logic                       i_call,
  input  logic                       i_ret,
  output logic [INST_ADDR_WIDTH-1:0] o_pc_out,
  output logic                       o_pc_valid,
  output logic                       o_halted,
  output logic                       o_ras_overflow,
  output logic                       o_ras_underflow
);

  localparam logic [INST_ADDR_WIDTH-1:0] RST_PC = INST_ADDR_WIDTH'(RESET_VECTOR);
  localparam logic [INST_ADDR_WIDTH-1:0] INC    = INST_ADDR_WIDTH'(NUM_BYTES_IN_INST);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t                     r_state, w_state_nxt;
  logic [INST_ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
  logic                       r_valid, w_valid_nxt;
  logic                       r_ovf, w_ovf_nxt;
  logic                       r_unf, w_unf_nxt;
  logic [INST_ADDR_WIDTH-1:0] w_pc_seq;

  assign w_pc_seq = r_pc + INC;

`ifdef PC_SEQ_RAS_EN
  localparam int                PW   = $clog2(RAS_DEPTH);
  localparam logic [PW:0]       FULL = (PW+1)'(RAS_DEPTH);

  // r_ptr is the next write slot; wrapping it means a push into a full stack
  // overwrites the oldest entry.
  logic [INST_ADDR_WIDTH-1:0] r_stack [RAS_DEPTH];
  logic [PW-1:0]              r_ptr;
  logic [PW:0]                r_cnt;
  logic [PW-1:0]              w_top;
  logic                       w_push, w_pop;

  assign w_top = r_ptr - 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_push) begin
      r_ptr <= r_ptr + 1'b1;
      if (r_cnt != FULL) r_cnt <= r_cnt + 1'b1;
    end else if (w_pop) begin
      r_ptr <= w_top;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Contents are don't-care after reset; only pointer and count are cleared.
  always_ff @(posedge i_clk) begin
    if (w_push) r_stack[r_ptr] <= w_pc_seq;
  end
`else
  logic w_unused;
  assign w_unused = i_ret | (RAS_DEPTH < 2);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = 1'b0;
    w_ovf_nxt   = 1'b0;
    w_unf_nxt   = 1'b0;
`ifdef PC_SEQ_RAS_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
`endif
    case (r_state)
      S_RUN: begin
        if (i_halt) begin
          w_state_nxt = S_HALTED;
        end else begin
          w_valid_nxt = 1'b1;
          if (i_stall) begin
            w_pc_nxt = r_pc;
`ifdef PC_SEQ_RAS_EN
          end else if (i_ret) begin
            if (r_cnt != '0) begin
              w_pc_nxt = r_stack[w_top];
              w_pop    = 1'b1;
            end else begin
              w_pc_nxt  = w_pc_seq;
              w_unf_nxt = 1'b1;
            end
          end else if (i_call) begin
            w_push    = 1'b1;
            w_ovf_nxt = (r_cnt == FULL);
            w_pc_nxt  = i_branch_addr;
          end else if (i_branch) begin
            w_pc_nxt = i_branch_addr;
`else
          end else if (i_call || i_branch) begin
            w_pc_nxt = i_branch_addr;
`endif
          end else begin
            w_pc_nxt = w_pc_seq;
          end
        end
      end
      S_HALTED: begin
        // halt wins over a simultaneous resume
        if (i_resume && !i_halt) begin
          w_state_nxt = S_RUN;
          w_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_RUN;
      r_pc    <= RST_PC;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  assign o_pc_out        = r_pc;
  assign o_pc_valid      = r_valid;
  assign o_halted        = (r_state == S_HALTED);
  assign o_ras_overflow  = r_ovf;
  assign o_ras_underflow = r_unf;

endmodule
